uart_tx_ctrl: RTL and testbench

//   Frame controller for the UART transmitter: accepts a byte on a valid strobe and

---
 rtl/uart_tx_ctrl_pkg.sv | 16 +
 rtl/uart_tx_serializer.sv | 44 ++++
 rtl/uart_tx_ctrl.sv | 92 +++++++++
 tb/tb_uart_tx_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: frame state encodings and parity selectors.
// The parity calculator uses the same PAR_* values.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b1;
  localparam logic PAR_ODD  = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the accepted frame byte and walks a bit index across it, LSB first.
// ser_data is the bit that goes out on the next DATA cycle.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;

  // ser_done rises once the final bit has been handed out and the index has wrapped
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      bit_cnt  <= '0;
      ser_done <= 1'b0;
    end else if (load) begin
      data_q   <= din;
      bit_cnt  <= '0;
      ser_done <= 1'b0;
    end else if (shift_en) begin
      if (bit_cnt == LAST) begin
        bit_cnt  <= '0;
        ser_done <= 1'b1;
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
        ser_done <= 1'b0;
      end
    end
  end

  assign ser_data = data_q[bit_cnt];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop bits.
// Every output is a register loaded from the next-state view, so it changes with the state.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  parity,
  output logic [DATA_WIDTH-1:0] parity_data,
  output logic                  parity_type,
  output logic                  parity_en,
  output logic                  busy,
  output logic                  tx_out
);

  state_t state, state_nx;
  logic   pen_q;
  logic   stop_cnt;
  logic   stop_last;
  logic   accept;
  logic   ser_data, ser_done;
  logic   tx_nx, busy_nx, pstrobe_nx;

  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign accept    = data_valid && ((state == ST_IDLE) || ((state == ST_STOP) && stop_last));

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk1     (clk1),
    .rst      (rst),
    .load     (accept),
    .shift_en (state_nx == ST_DATA),
    .din      (p_data),
    .data_q   (parity_data),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      parity_en   <= 1'b0;
      parity_type <= 1'b0;
      pen_q       <= 1'b0;
      stop_cnt    <= 1'b0;
    end else begin
      state     <= state_nx;
      tx_out    <= tx_nx;
      busy      <= busy_nx;
      parity_en <= pstrobe_nx;
      stop_cnt  <= ((state == ST_STOP) && !stop_last) ? stop_cnt + 1'b1 : 1'b0;
      if (accept) begin
        pen_q       <= par_en;
        parity_type <= par_typ;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_START;
      ST_START:  state_nx = ST_DATA;
      ST_DATA:   if (ser_done) state_nx = pen_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nx = ST_STOP;
      ST_STOP:   if (stop_last) state_nx = accept ? ST_START : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Parity is captured by the calculator at the end of START, long before PARITY needs it
  always_comb begin
    tx_nx      = 1'b1;
    busy_nx    = (state_nx != ST_IDLE);
    pstrobe_nx = (state_nx == ST_START);
    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = ser_data;
      ST_PARITY: tx_nx = parity;
      default:   tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a 1-stop-bit instance driven from a vector table
// plus hand sequences, and a 2-stop-bit instance for the stop-cycle accept window.
module tb_uart_tx_ctrl;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic       rst;
  logic [7:0] p_data, p_data2;
  logic       data_valid, dv2, par_en, par_en2, par_typ, par_typ2;
  logic       parity = 1'b0, parity2 = 1'b0;
  logic [7:0] parity_data, parity_data2;
  logic       parity_type, parity_type2, parity_en, parity_en2;
  logic       busy, busy2, tx_out, tx_out2;

  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk1(clk1), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .parity(parity),
    .parity_data(parity_data), .parity_type(parity_type), .parity_en(parity_en),
    .busy(busy), .tx_out(tx_out)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk1(clk1), .rst(rst), .p_data(p_data2), .data_valid(dv2),
    .par_en(par_en2), .par_typ(par_typ2), .parity(parity2),
    .parity_data(parity_data2), .parity_type(parity_type2), .parity_en(parity_en2),
    .busy(busy2), .tx_out(tx_out2)
  );

  // External parity calculator: registered, captures on parity_en (even -> XOR of data)
  always @(posedge clk1) begin
    if (parity_en)  parity  <= parity_type  ? ^parity_data  : ~^parity_data;
    if (parity_en2) parity2 <= parity_type2 ? ^parity_data2 : ~^parity_data2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the negedge where frame cycle 0 (start bit) is visible; bits[11-i] is cycle i
  task automatic check_frame(input bit sel, input logic [11:0] bits, input int len,
                             input bit disturb, input int id);
    for (int i = 0; i < len; i++) begin
      chk1($sformatf("f%0d c%0d tx_out", id, i), sel ? tx_out2 : tx_out, bits[11-i]);
      chk1($sformatf("f%0d c%0d busy", id, i), sel ? busy2 : busy, 1'b1);
      chk1($sformatf("f%0d c%0d parity_en", id, i), sel ? parity_en2 : parity_en, 1'(i == 0));
      if (disturb && i == 3) begin
        data_valid = 1'b1;
        p_data     = ~p_data;
        par_en     = ~par_en;
      end
      if (disturb && i == 4) data_valid = 1'b0;
      @(negedge clk1);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    logic [11:0] bits;
    int          len;
    bit          disturb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 12'b010100101100, 10, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 12'b010100101010, 11, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 12'b010000000110, 11, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 12'b010000000010, 11, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 12'b000000000110, 11, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 12'b000111100010, 11, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 12'b011111111100, 10, 1'b0};

    rst = 1'b0;
    p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    p_data2 = 8'h00; dv2 = 1'b0; par_en2 = 1'b0; par_typ2 = 1'b0;
    repeat (2) @(negedge clk1);
    chk1("reset tx_out", tx_out, 1'b1);
    chk1("reset busy", busy, 1'b0);
    chk1("reset parity_en", parity_en, 1'b0);
    chk8("reset parity_data", parity_data, 8'h00);
    chk1("reset parity_type", parity_type, 1'b0);
    chk1("reset tx_out2", tx_out2, 1'b1);
    chk1("reset busy2", busy2, 1'b0);
    rst = 1'b1;
    @(negedge clk1);
    chk1("idle tx_out", tx_out, 1'b1);

    for (int v = 0; v < 7; v++) begin
      data_valid = 1'b1;
      p_data     = vecs[v].data;
      par_en     = vecs[v].pen;
      par_typ    = vecs[v].ptyp;
      @(negedge clk1);
      data_valid = 1'b0;
      p_data     = ~vecs[v].data;
      par_en     = ~vecs[v].pen;
      par_typ    = ~vecs[v].ptyp;
      chk8($sformatf("v%0d parity_data", v), parity_data, vecs[v].data);
      chk1($sformatf("v%0d parity_type", v), parity_type, vecs[v].ptyp);
      check_frame(1'b0, vecs[v].bits, vecs[v].len, vecs[v].disturb, v);
      chk1($sformatf("v%0d after busy", v), busy, 1'b0);
      chk1($sformatf("v%0d after tx_out", v), tx_out, 1'b1);
    end

    // Back-to-back: data_valid held high across the stop bit
    data_valid = 1'b1; p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk1);
    p_data = 8'hC3;
    check_frame(1'b0, 12'b000111100100, 10, 1'b0, 10);
    data_valid = 1'b0;
    check_frame(1'b0, 12'b011000011100, 10, 1'b0, 11);
    chk1("b2b after busy", busy, 1'b0);

    // Reset asserted during DATA bit 3
    data_valid = 1'b1; p_data = 8'hA5; par_en = 1'b0;
    @(negedge clk1);
    data_valid = 1'b0;
    repeat (4) @(negedge clk1);
    chk1("pre-reset tx_out bit3", tx_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("async reset tx_out", tx_out, 1'b1);
    chk1("async reset busy", busy, 1'b0);
    chk1("async reset parity_en", parity_en, 1'b0);
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    chk1("post-reset idle busy", busy, 1'b0);
    data_valid = 1'b1; p_data = 8'h01; par_en = 1'b1; par_typ = 1'b1;
    @(negedge clk1);
    data_valid = 1'b0;
    check_frame(1'b0, 12'b010000000110, 11, 1'b0, 12);
    chk1("post-reset frame busy", busy, 1'b0);

    // Two stop bits: request in the first stop cycle waits for the second
    dv2 = 1'b1; p_data2 = 8'h5A;
    @(negedge clk1);
    dv2 = 1'b0;
    check_frame(1'b1, 12'b001011010110, 9, 1'b0, 20);
    chk1("stop2 c9 tx_out", tx_out2, 1'b1);
    chk1("stop2 c9 busy", busy2, 1'b1);
    dv2 = 1'b1; p_data2 = 8'h81;
    @(negedge clk1);
    chk1("stop2 c10 tx_out", tx_out2, 1'b1);
    chk1("stop2 c10 busy", busy2, 1'b1);
    @(negedge clk1);
    dv2 = 1'b0;
    check_frame(1'b1, 12'b010000001110, 11, 1'b0, 21);
    chk1("stop2 after busy", busy2, 1'b0);
    chk1("stop2 after tx_out", tx_out2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
